// File: rtl/reader_cmd_seq.sv
// Reader command sequencer: shifts a latched command MSB-first into the PIE encoder,
// waits T1 after the encoder idles, then opens the receive window until reply or timeout.
`timescale 1ns/1ps
module reader_cmd_seq #(
    parameter int unsigned T1_CYCLES  = 40,
    parameter int unsigned RX_TIMEOUT = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_rdy,
    input  logic [63:0] cmd_data,
    input  logic [6:0]  cmd_len,
    input  logic        cmd_preamble,
    input  logic        cmd_no_reply,
    output logic        enc_en,
    output logic        enc_bit,
    output logic        enc_preamble,
    input  logic        enc_in_rdy,
    input  logic        enc_idle,
    output logic        rx_en,
    input  logic        rx_done,
    output logic        done,
    output logic [1:0]  status
);

    typedef enum logic [2:0] {StIdle, StTx, StDrain, StT1Wait, StRx} state_e;

    localparam logic [1:0] StatOk      = 2'b00;
    localparam logic [1:0] StatTimeout = 2'b01;
    localparam logic [1:0] StatLenErr  = 2'b10;
    localparam logic [1:0] StatNoReply = 2'b11;

    // One extra bit so limits up to 2^16-1 compare cleanly against count+1.
    localparam logic [16:0] T1Lim = 17'(T1_CYCLES);
    localparam logic [16:0] RxLim = 17'(RX_TIMEOUT);

    state_e      state_q, state_d;
    logic [63:0] data_q, data_d;
    logic [5:0]  idx_q, idx_d;
    logic        pre_q, pre_d;
    logic        no_reply_q, no_reply_d;
    logic [15:0] cnt_q, cnt_d;
    logic        done_q, done_d;
    logic [1:0]  status_q, status_d;
    logic [16:0] cnt_inc;

    assign cnt_inc = {1'b0, cnt_q} + 17'd1;

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        idx_d      = idx_q;
        pre_d      = pre_q;
        no_reply_d = no_reply_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        status_d   = status_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    data_d     = cmd_data;
                    idx_d      = 6'(cmd_len - 7'd1);
                    pre_d      = cmd_preamble;
                    no_reply_d = cmd_no_reply;
                    if (cmd_len == 7'd0 || cmd_len > 7'd64) begin
                        done_d   = 1'b1;
                        status_d = StatLenErr;
                    end else begin
                        state_d = StTx;
                    end
                end
            end
            StTx: begin
                if (enc_in_rdy) begin
                    if (idx_q == 6'd0) state_d = StDrain;
                    else               idx_d   = idx_q - 6'd1;
                end
            end
            StDrain: begin
                if (enc_idle) begin
                    if (no_reply_q) begin
                        state_d  = StIdle;
                        done_d   = 1'b1;
                        status_d = StatNoReply;
                    end else begin
                        state_d = StT1Wait;
                        cnt_d   = 16'd0;
                    end
                end
            end
            StT1Wait: begin
                if (cnt_inc >= T1Lim) begin
                    state_d = StRx;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_inc[15:0];
                end
            end
            StRx: begin
                // A reply landing on the final window cycle still counts as success.
                if (rx_done) begin
                    state_d  = StIdle;
                    done_d   = 1'b1;
                    status_d = StatOk;
                end else if (cnt_inc >= RxLim) begin
                    state_d  = StIdle;
                    done_d   = 1'b1;
                    status_d = StatTimeout;
                end else begin
                    cnt_d = cnt_inc[15:0];
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            data_q     <= 64'd0;
            idx_q      <= 6'd0;
            pre_q      <= 1'b0;
            no_reply_q <= 1'b0;
            cnt_q      <= 16'd0;
            done_q     <= 1'b0;
            status_q   <= StatOk;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            idx_q      <= idx_d;
            pre_q      <= pre_d;
            no_reply_q <= no_reply_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            status_q   <= status_d;
        end
    end

    assign cmd_rdy      = (state_q == StIdle);
    assign enc_en       = (state_q == StTx);
    assign enc_bit      = (state_q == StTx) & data_q[idx_q];
    assign enc_preamble = (state_q == StTx || state_q == StDrain) & pre_q;
    assign rx_en        = (state_q == StRx);
    assign done         = done_q;
    assign status       = status_q;

endmodule

// File: tb/tb_reader_cmd_seq.sv
// Directed bench for reader_cmd_seq; expected statuses are queued at issue time and
// checked against each done pulse.
`timescale 1ns/1ps
module tb_reader_cmd_seq;

    logic        clk = 1'b0;
    logic        rst, cmd_valid, cmd_rdy, cmd_preamble, cmd_no_reply;
    logic [63:0] cmd_data;
    logic [6:0]  cmd_len;
    logic        enc_en, enc_bit, enc_preamble, enc_in_rdy, enc_idle;
    logic        rx_en, rx_done, done;
    logic [1:0]  status;

    int errors = 0;
    int checks = 0;
    int rx_cycles = 0;
    int en_cycles = 0;
    logic [1:0] exp_q[$];

    always #5 clk = ~clk;

    reader_cmd_seq #(.T1_CYCLES(40), .RX_TIMEOUT(1000)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_rdy     (cmd_rdy),
        .cmd_data    (cmd_data),
        .cmd_len     (cmd_len),
        .cmd_preamble(cmd_preamble),
        .cmd_no_reply(cmd_no_reply),
        .enc_en      (enc_en),
        .enc_bit     (enc_bit),
        .enc_preamble(enc_preamble),
        .enc_in_rdy  (enc_in_rdy),
        .enc_idle    (enc_idle),
        .rx_en       (rx_en),
        .rx_done     (rx_done),
        .done        (done),
        .status      (status)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard and activity counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (rx_en) rx_cycles++;
        if (enc_en) en_cycles++;
        if (done) begin
            chk("done_expected", 64'(exp_q.size() != 0), 64'd1);
            chk("cmd_rdy_with_done", 64'(cmd_rdy), 64'd1);
            if (exp_q.size() != 0) chk("status", 64'(status), 64'(exp_q.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [63:0] d, input logic [6:0] l, input logic p,
                         input logic nr);
        cmd_data = d; cmd_len = l; cmd_preamble = p; cmd_no_reply = nr;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        // Scramble inputs: the DUT must work from its latched copy.
        cmd_data = ~d; cmd_len = 7'd33; cmd_preamble = ~p; cmd_no_reply = ~nr;
    endtask

    // Encoder model: consumes one bit every 8 cycles, checking each presented bit.
    task automatic send_bits(input logic [63:0] d, input int len, input int nbits,
                             input logic p);
        for (int i = len - 1; i >= len - nbits; i--) begin
            chk("enc_en_tx", 64'(enc_en), 64'd1);
            chk("enc_preamble_tx", 64'(enc_preamble), 64'(p));
            chk($sformatf("enc_bit[%0d]", i), 64'(enc_bit), 64'(d[i]));
            repeat (7) tick();
            chk($sformatf("enc_bit_stable[%0d]", i), 64'(enc_bit), 64'(d[i]));
            enc_in_rdy = 1'b1;
            tick();
            enc_in_rdy = 1'b0;
        end
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        while (!done && n < bound) begin
            tick();
            n++;
        end
        chk("done_within_bound", 64'(done), 64'd1);
    endtask

    task automatic drain_idle();
        chk("enc_en_drain", 64'(enc_en), 64'd0);
        repeat (3) tick();
        enc_idle = 1'b1;
        tick();
        enc_idle = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1; cmd_valid = 1'b0; cmd_data = '0; cmd_len = '0;
        cmd_preamble = 1'b0; cmd_no_reply = 1'b0;
        enc_in_rdy = 1'b0; enc_idle = 1'b0; rx_done = 1'b0;
        repeat (3) tick();
        chk("rst_cmd_rdy", 64'(cmd_rdy), 64'd1);
        chk("rst_enc_en", 64'(enc_en), 64'd0);
        chk("rst_enc_bit", 64'(enc_bit), 64'd0);
        chk("rst_enc_pre", 64'(enc_preamble), 64'd0);
        chk("rst_rx_en", 64'(rx_en), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_status", 64'(status), 64'd0);
        rst = 1'b0;
        tick();

        // Short no-reply command: bits 1,0,1,0 then status 11 on encoder idle.
        exp_q.push_back(2'b11);
        issue(64'hA, 7'd4, 1'b0, 1'b1);
        chk("cmd_rdy_busy", 64'(cmd_rdy), 64'd0);
        send_bits(64'hA, 4, 4, 1'b0);
        chk("enc_en_drain", 64'(enc_en), 64'd0);
        repeat (5) tick();
        chk("no_done_before_idle", 64'(done), 64'd0);
        rx_done = 1'b1; // ignored outside RX
        enc_idle = 1'b1;
        tick();
        enc_idle = 1'b0; rx_done = 1'b0;
        chk("done_a", 64'(done), 64'd1);
        tick();
        chk("done_single_cycle", 64'(done), 64'd0);

        // 22-bit command with preamble and reply at RX cycle 50.
        exp_q.push_back(2'b00);
        issue(64'h2D5A3C, 7'd22, 1'b1, 1'b0);
        send_bits(64'h2D5A3C, 22, 22, 1'b1);
        chk("enc_pre_drain", 64'(enc_preamble), 64'd1);
        drain_idle();
        chk("enc_pre_t1", 64'(enc_preamble), 64'd0);
        rx_cycles = 0;
        n = 0;
        while (!rx_en && n < 100) begin
            tick();
            n++;
        end
        chk("t1_wait_cycles", 64'(n), 64'd40);
        repeat (49) tick();
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        chk("done_b", 64'(done), 64'd1);
        chk("rx_en_cycles_b", 64'(rx_cycles), 64'd50);
        tick();

        // No reply: window must stay open exactly RX_TIMEOUT cycles.
        exp_q.push_back(2'b01);
        issue(64'h2, 7'd2, 1'b0, 1'b0);
        send_bits(64'h2, 2, 2, 1'b0);
        drain_idle();
        rx_cycles = 0;
        wait_done(1200);
        chk("rx_en_cycles_timeout", 64'(rx_cycles), 64'd1000);
        tick();

        // Length errors.
        en_cycles = 0;
        exp_q.push_back(2'b10);
        issue(64'hFF, 7'd0, 1'b0, 1'b0);
        chk("done_len0", 64'(done), 64'd1);
        tick();
        exp_q.push_back(2'b10);
        issue(64'hFF, 7'd65, 1'b1, 1'b0);
        chk("done_len65", 64'(done), 64'd1);
        tick();
        chk("enc_en_never_len_err", 64'(en_cycles), 64'd0);

        // Reset mid-TX: no done, then a fresh command runs normally.
        issue(64'hC3, 7'd8, 1'b1, 1'b1);
        send_bits(64'hC3, 8, 3, 1'b1);
        rst = 1'b1; enc_in_rdy = 1'b1; enc_idle = 1'b1;
        tick();
        rst = 1'b0; enc_in_rdy = 1'b0; enc_idle = 1'b0;
        chk("abort_cmd_rdy", 64'(cmd_rdy), 64'd1);
        chk("abort_enc_en", 64'(enc_en), 64'd0);
        chk("abort_enc_bit", 64'(enc_bit), 64'd0);
        chk("abort_enc_pre", 64'(enc_preamble), 64'd0);
        chk("abort_rx_en", 64'(rx_en), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_status", 64'(status), 64'd0);
        exp_q.push_back(2'b11);
        issue(64'h5, 7'd3, 1'b0, 1'b1);
        send_bits(64'h5, 3, 3, 1'b0);
        drain_idle();
        chk("done_after_abort", 64'(done), 64'd1);
        tick();

        // rx_done coincides with timeout; cmd_valid held throughout the busy period.
        exp_q.push_back(2'b00);
        cmd_data = 64'h1; cmd_len = 7'd1; cmd_preamble = 1'b0; cmd_no_reply = 1'b0;
        cmd_valid = 1'b1;
        tick();
        chk("held_cmd_rdy_low", 64'(cmd_rdy), 64'd0);
        send_bits(64'h1, 1, 1, 1'b0);
        drain_idle();
        n = 0;
        while (!rx_en && n < 100) begin
            tick();
            n++;
        end
        rx_cycles = 0;
        repeat (999) begin
            chk("held_no_accept", 64'(cmd_rdy), 64'd0);
            tick();
        end
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        chk("done_tie", 64'(done), 64'd1);
        chk("rx_en_cycles_tie", 64'(rx_cycles), 64'd1000);
        // Held request is taken on the done cycle; make it a length error to see it.
        exp_q.push_back(2'b10);
        cmd_len = 7'd0;
        tick();
        cmd_valid = 1'b0;
        chk("second_cmd_done", 64'(done), 64'd1);
        repeat (3) tick();

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reader_cmd_seq.md
READER_CMD_SEQ -- requirements
Module: reader_cmd_seq

Interface
REQ-001 SHALL have parameter T1_CYCLES, default 40, meaning idle cycles between encoder-idle and receive-window open.
REQ-002 SHALL have parameter RX_TIMEOUT, default 1000, meaning max receive-window cycles before timeout.
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port cmd_valid  input  1  command offered.
REQ-006 SHALL have port cmd_rdy  output  1  sequencer can accept a command.
REQ-007 SHALL have port cmd_data  input  64  command bits, right-aligned.
REQ-008 SHALL have port cmd_len  input  7  number of valid bits, 1..64.
REQ-009 SHALL have port cmd_preamble  input  1  1 = full preamble (TRcal), 0 = frame-sync.
REQ-010 SHALL have port cmd_no_reply  input  1  1 = skip T1 wait and receive window.
REQ-011 SHALL have port enc_en  output  1  enables PIE encoder; encoder outputs CW when low.
REQ-012 SHALL have port enc_bit  output  1  current bit presented to encoder.
REQ-013 SHALL have port enc_preamble  output  1  preamble select to encoder, held for whole frame.
REQ-014 SHALL have port enc_in_rdy  input  1  one-cycle pulse: encoder consumed enc_bit.
REQ-015 SHALL have port enc_idle  input  1  encoder finished final symbol.
REQ-016 SHALL have port rx_en  output  1  receive window open (FM0 decoder enable).
REQ-017 SHALL have port rx_done  input  1  decoder reports end of reply frame.
REQ-018 SHALL have port done  output  1  one-cycle pulse: command sequence complete.
REQ-019 SHALL have port status  output  2  valid with done: 00 ok, 01 timeout, 10 length error, 11 no-reply ok.

Function
REQ-020 SHALL implement states IDLE, TX, DRAIN, T1WAIT, RX.
REQ-021 SHALL assert cmd_rdy only in IDLE; command accepted when cmd_valid && cmd_rdy.
REQ-022 SHALL on accept latch cmd_data, cmd_len, cmd_preamble, cmd_no_reply; later input changes ignored.
REQ-023 SHALL on accept with cmd_len 0 or >64 stay IDLE, pulse done next cycle with status 10, never assert enc_en.
REQ-024 SHALL on valid accept enter TX next cycle with enc_en=1, enc_bit = cmd_data[cmd_len-1].
REQ-025 SHALL in TX advance MSB-first (index len-1 down to 0) one bit per enc_in_rdy pulse; enc_bit stable between pulses.
REQ-026 SHALL on enc_in_rdy consuming bit 0 deassert enc_en next cycle and enter DRAIN.
REQ-027 SHALL in DRAIN wait for enc_idle=1, then enter T1WAIT, or return to IDLE with done, status 11 if no_reply.
REQ-028 SHALL in T1WAIT count exactly T1_CYCLES cycles then enter RX.
REQ-029 SHALL in RX hold rx_en=1; on rx_done return to IDLE with done, status 00.
REQ-030 SHALL in RX after RX_TIMEOUT cycles without rx_done return to IDLE with done, status 01.
REQ-031 SHALL give rx_done priority over timeout when both occur same cycle.
REQ-032 SHALL ignore enc_in_rdy outside TX and rx_done outside RX.
REQ-033 SHALL keep enc_preamble equal to latched cmd_preamble from TX entry until DRAIN exit; 0 in IDLE.
REQ-034 SHALL size counters for parameter values up to 2^16-1 without wrap.
REQ-035 SHALL make done a single-cycle pulse concurrent with return to IDLE; cmd_rdy high that same cycle.

Reset
REQ-036 SHALL on rst force IDLE: cmd_rdy=1, enc_en=0, enc_bit=0, enc_preamble=0, rx_en=0, done=0, status=00.
REQ-037 SHALL abort any in-progress command on rst with no done pulse; rst overrides all same-cycle inputs.

Verification
REQ-038 SHALL cover: cmd_len=4, cmd_data=0xA, no_reply=1, in_rdy every 8 cycles -> enc_bit 1,0,1,0; done with status 11 after enc_idle.
REQ-039 SHALL cover: cmd_len=22, preamble=1, reply expected, rx_done 50 cycles into RX -> rx_en high exactly 50 cycles after T1_CYCLES=40 wait; status 00.
REQ-040 SHALL cover: no rx_done -> rx_en high RX_TIMEOUT cycles, done with status 01.
REQ-041 SHALL cover: cmd_len=0 and cmd_len=65 -> done status 10, enc_en never high.
REQ-042 SHALL cover: rst asserted mid-TX after 3 bits -> next cycle all outputs at reset values, no done; new command then runs normally.
REQ-043 SHALL cover: rx_done and timeout in same cycle -> status 00; cmd_valid held during busy -> second command accepted only after done.
